// File: rtl/ldq_issue_if.sv
// Handshake and status bundle between the load queue / memory side and the
// LDQ issue controller. The controller uses the master modport.
interface ldq_issue_if #(
    parameter int LDQ_SIZE = 16,
    localparam int IDX_W = $clog2(LDQ_SIZE)
);
    logic                dispatch_valid;
    logic                dispatch_ready;
    logic [IDX_W-1:0]    alloc_index;

    logic [LDQ_SIZE-1:0] entry_valid;
    logic [LDQ_SIZE-1:0] entry_address_valid;
    logic [LDQ_SIZE-1:0] entry_executed;
    logic [LDQ_SIZE-1:0] entry_blocked;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic [IDX_W-1:0]    mem_req_index;
    logic                mem_resp_valid;

    logic                load_executed;
    logic [IDX_W-1:0]    load_executed_index;
    logic                load_succeeded;
    logic [IDX_W-1:0]    load_succeeded_index;

    logic                rob_commit_load;
    logic [IDX_W-1:0]    head_index;
    logic [IDX_W:0]      count;
    logic                flush;

    modport master (
        input  dispatch_valid, entry_valid, entry_address_valid, entry_executed,
               entry_blocked, mem_req_ready, mem_resp_valid, rob_commit_load, flush,
        output dispatch_ready, alloc_index, mem_req_valid, mem_req_index,
               load_executed, load_executed_index, load_succeeded,
               load_succeeded_index, head_index, count
    );

    modport slave (
        output dispatch_valid, entry_valid, entry_address_valid, entry_executed,
               entry_blocked, mem_req_ready, mem_resp_valid, rob_commit_load, flush,
        input  dispatch_ready, alloc_index, mem_req_valid, mem_req_index,
               load_executed, load_executed_index, load_succeeded,
               load_succeeded_index, head_index, count
    );
endinterface

// File: rtl/ldq_issue_controller.sv
// Load queue sequencer: head/tail/count bookkeeping, oldest-ready load
// selection and a single-outstanding request/response issue FSM.
module ldq_issue_controller #(
    parameter int LDQ_SIZE = 16,
    localparam int IDX_W = $clog2(LDQ_SIZE)
) (
    input  logic          clk,
    input  logic          reset,
    ldq_issue_if.master   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [IDX_W:0]      head_q, tail_q, count_q, head_d;
    logic                full, empty, alloc, commit;
    logic [LDQ_SIZE-1:0] cand;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_index, probe;
    logic [1:0]          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                req_valid, executed_pulse, succeeded_pulse;

    assign full   = (count_q == (IDX_W+1)'(LDQ_SIZE));
    assign empty  = (count_q == '0);
    assign alloc  = bus.dispatch_valid && !full;
    assign commit = bus.rob_commit_load && !empty;
    assign head_d = head_q + {{IDX_W{1'b0}}, commit};

    // Pointers carry a wrap bit; a flush retires the same-cycle commit first
    // and then collapses the queue onto the new head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            head_q <= head_d;
            if (bus.flush) begin
                tail_q  <= head_d;
                count_q <= '0;
            end else begin
                if (alloc) tail_q <= tail_q + 1'b1;
                case ({alloc, commit})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign cand = bus.entry_valid & bus.entry_address_valid
                & ~bus.entry_executed & ~bus.entry_blocked;

    // Oldest-first scan starting at head; the index adder wraps modulo LDQ_SIZE.
    always_comb begin
        // NOTE: defaults first so no path through the block infers a latch.
        sel_found = 1'b0;
        sel_index = '0;
        probe     = '0;
        for (int i = 0; i < LDQ_SIZE; i++) begin
            probe = head_q[IDX_W-1:0] + IDX_W'(i);
            if (!sel_found && cand[probe]) begin
                sel_found = 1'b1;
                sel_index = probe;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        req_valid       = 1'b0;
        executed_pulse  = 1'b0;
        succeeded_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.flush && sel_found) begin
                    state_d = REQ;
                    idx_d   = sel_index;
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (bus.mem_req_ready) begin
                    executed_pulse = !bus.flush;
                    state_d        = bus.flush ? DRAIN : WAIT;
                end else if (bus.flush) begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid) begin
                    succeeded_pulse = !bus.flush;
                    state_d         = IDLE;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            // A flushed request still owes the memory port its response.
            DRAIN: begin
                if (bus.mem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.dispatch_ready       = !full;
    assign bus.alloc_index          = tail_q[IDX_W-1:0];
    assign bus.head_index           = head_q[IDX_W-1:0];
    assign bus.count                = count_q;
    assign bus.mem_req_valid        = req_valid;
    assign bus.mem_req_index        = idx_q;
    assign bus.load_executed        = executed_pulse;
    assign bus.load_executed_index  = idx_q;
    assign bus.load_succeeded       = succeeded_pulse;
    assign bus.load_succeeded_index = idx_q;

endmodule

// File: tb/tb_ldq_issue_controller.sv
// Directed bench for ldq_issue_controller: allocation/commit, oldest-first
// issue with wrap-around, blocking, flush drain and asynchronous reset.
module tb_ldq_issue_controller;

    localparam int LDQ_SIZE = 16;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    ldq_issue_if #(.LDQ_SIZE(LDQ_SIZE)) bus ();

    ldq_issue_controller #(.LDQ_SIZE(LDQ_SIZE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow a further #1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        bus.dispatch_valid      = 1'b0;
        bus.entry_valid         = '1;
        bus.entry_address_valid = '0;
        bus.entry_executed      = '0;
        bus.entry_blocked       = '0;
        bus.mem_req_ready       = 1'b0;
        bus.mem_resp_valid      = 1'b0;
        bus.rob_commit_load     = 1'b0;
        bus.flush               = 1'b0;
        #1;
        check("reset_count",  32'(bus.count), 32'd0);
        check("reset_ready",  32'(bus.dispatch_ready), 32'd1);
        check("reset_req",    32'(bus.mem_req_valid), 32'd0);
        check("reset_head",   32'(bus.head_index), 32'd0);
        check("reset_alloc",  32'(bus.alloc_index), 32'd0);
        check("reset_exec",   32'(bus.load_executed), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Fill the queue: 16 allocations, indices 0..15.
        for (int i = 0; i < LDQ_SIZE; i++) begin
            bus.dispatch_valid = 1'b1;
            #1;
            check($sformatf("alloc_index_%0d", i), 32'(bus.alloc_index), 32'(i));
            tick();
        end
        bus.dispatch_valid = 1'b0;
        #1;
        check("full_ready", 32'(bus.dispatch_ready), 32'd0);
        check("full_count", 32'(bus.count), 32'd16);

        // 17th dispatch with a commit in the same cycle is refused.
        bus.dispatch_valid  = 1'b1;
        bus.rob_commit_load = 1'b1;
        tick();
        bus.dispatch_valid  = 1'b0;
        bus.rob_commit_load = 1'b0;
        #1;
        check("refuse_count", 32'(bus.count), 32'd15);
        check("refuse_head",  32'(bus.head_index), 32'd1);
        check("refuse_tail",  32'(bus.alloc_index), 32'd0);

        // Entry 3 becomes a candidate; memory stalls for two cycles.
        bus.entry_address_valid = 16'h0008;
        #1;
        check("e3_no_req_same_cycle", 32'(bus.mem_req_valid), 32'd0);
        tick();
        check("e3_req_n1",   32'(bus.mem_req_valid), 32'd1);
        check("e3_idx_n1",   32'(bus.mem_req_index), 32'd3);
        check("e3_noexec_n1", 32'(bus.load_executed), 32'd0);
        tick();
        check("e3_req_n2",   32'(bus.mem_req_valid), 32'd1);
        check("e3_idx_n2",   32'(bus.mem_req_index), 32'd3);
        tick();
        bus.mem_req_ready = 1'b1;
        #1;
        check("e3_exec",     32'(bus.load_executed), 32'd1);
        check("e3_exec_idx", 32'(bus.load_executed_index), 32'd3);
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.entry_executed = 16'h0008;
        #1;
        check("e3_exec_pulse_end", 32'(bus.load_executed), 32'd0);
        check("e3_wait_no_req",    32'(bus.mem_req_valid), 32'd0);
        tick();
        bus.mem_resp_valid = 1'b1;
        #1;
        check("e3_succ",     32'(bus.load_succeeded), 32'd1);
        check("e3_succ_idx", 32'(bus.load_succeeded_index), 32'd3);
        tick();
        #1;
        check("idle_resp_ignored", 32'(bus.load_succeeded), 32'd0);
        bus.mem_resp_valid = 1'b0;

        // Move head to 14 and add four entries (tail wraps to 4).
        bus.rob_commit_load = 1'b1;
        repeat (13) tick();
        bus.rob_commit_load = 1'b0;
        bus.dispatch_valid  = 1'b1;
        repeat (4) tick();
        bus.dispatch_valid  = 1'b0;
        #1;
        check("wrap_head",  32'(bus.head_index), 32'd14);
        check("wrap_count", 32'(bus.count), 32'd6);

        // Candidates at 1 and 15: 15 is older relative to head 14.
        bus.entry_executed      = '0;
        bus.entry_address_valid = 16'h8002;
        tick();
        check("wrap_first_idx", 32'(bus.mem_req_index), 32'd15);
        bus.mem_req_ready = 1'b1;
        #1;
        check("wrap_first_exec", 32'(bus.load_executed_index), 32'd15);
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.entry_executed = 16'h8000;
        #1;
        check("wrap_single_outstanding", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        #1;
        check("wrap_first_succ", 32'(bus.load_succeeded_index), 32'd15);
        tick();
        bus.mem_resp_valid = 1'b0;
        tick();
        check("wrap_second_req", 32'(bus.mem_req_valid), 32'd1);
        check("wrap_second_idx", 32'(bus.mem_req_index), 32'd1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.entry_executed = 16'h8002;
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;

        // Entry 5 blocked by an older store: no issue until released.
        bus.entry_executed      = '0;
        bus.entry_address_valid = 16'h0020;
        bus.entry_blocked       = 16'h0020;
        tick();
        tick();
        check("blocked_no_req", 32'(bus.mem_req_valid), 32'd0);
        bus.entry_blocked = '0;
        tick();
        check("unblocked_req", 32'(bus.mem_req_valid), 32'd1);
        check("unblocked_idx", 32'(bus.mem_req_index), 32'd5);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.entry_executed = 16'h0020;
        bus.mem_resp_valid = 1'b1;
        tick();
        bus.mem_resp_valid = 1'b0;

        // Bring queue to head=2, count=6.
        bus.rob_commit_load = 1'b1;
        repeat (4) tick();
        bus.rob_commit_load = 1'b0;
        bus.dispatch_valid  = 1'b1;
        repeat (4) tick();
        bus.dispatch_valid  = 1'b0;
        #1;
        check("flush_pre_head",  32'(bus.head_index), 32'd2);
        check("flush_pre_count", 32'(bus.count), 32'd6);

        // Issue entry 6, then flush while waiting for its response.
        bus.entry_executed      = '0;
        bus.entry_address_valid = 16'h0040;
        tick();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.entry_executed = 16'h0040;
        bus.flush          = 1'b1;
        bus.dispatch_valid = 1'b1;
        tick();
        bus.flush          = 1'b0;
        bus.dispatch_valid = 1'b0;
        #1;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_tail",  32'(bus.alloc_index), 32'd2);
        check("flush_head",  32'(bus.head_index), 32'd2);
        check("flush_ready", 32'(bus.dispatch_ready), 32'd1);
        bus.entry_address_valid = 16'h00C0;
        tick();
        check("drain_no_req", 32'(bus.mem_req_valid), 32'd0);
        bus.mem_resp_valid = 1'b1;
        #1;
        check("drain_no_succ", 32'(bus.load_succeeded), 32'd0);
        tick();
        bus.mem_resp_valid = 1'b0;
        #1;
        check("post_drain_idle", 32'(bus.mem_req_valid), 32'd0);
        tick();
        check("post_drain_req", 32'(bus.mem_req_valid), 32'd1);
        check("post_drain_idx", 32'(bus.mem_req_index), 32'd7);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.entry_executed = 16'h00C0;

        // Asynchronous reset in the middle of a WAIT cycle.
        bus.dispatch_valid = 1'b1;
        repeat (2) tick();
        bus.dispatch_valid = 1'b0;
        #1;
        check("pre_reset_count", 32'(bus.count), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_req",   32'(bus.mem_req_valid), 32'd0);
        check("async_count", 32'(bus.count), 32'd0);
        check("async_ready", 32'(bus.dispatch_ready), 32'd1);
        check("async_head",  32'(bus.head_index), 32'd0);
        tick();
        reset = 1'b0;
        bus.mem_resp_valid = 1'b1;
        #1;
        check("post_reset_resp_ignored", 32'(bus.load_succeeded), 32'd0);
        tick();
        bus.mem_resp_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ldq_issue_controller.md
Name: ldq_issue_controller

Overview:
Sequencing controller for the load queue. It owns the LDQ head/tail pointers and the allocation index, and picks the oldest ready load for issue. It drives a single-outstanding request/response handshake to the data-memory port and signals executed/succeeded events back into the load queue. It also frees committed entries and recovers from pipeline flushes.

Parameters:
LDQ_SIZE, 16, number of load queue entries (power of two, >=2)
IDX_W, $clog2(LDQ_SIZE), width of an entry index

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
dispatch_valid  input  1  dispatch requests one LDQ entry this cycle
dispatch_ready  output  1  entry available (not full)
alloc_index  output  IDX_W  index granted to dispatch (current tail)
entry_valid  input  LDQ_SIZE  per-entry valid bit from load queue
entry_address_valid  input  LDQ_SIZE  per-entry address resolved by AGU
entry_executed  input  LDQ_SIZE  per-entry already issued
entry_blocked  input  LDQ_SIZE  per-entry unresolved older-store dependence
mem_req_valid  output  1  load request to memory port
mem_req_ready  input  1  memory port accepts request
mem_req_index  output  IDX_W  LDQ index of the request
mem_resp_valid  input  1  response for the outstanding request
load_executed  output  1  one-cycle pulse: request accepted
load_executed_index  output  IDX_W  index for load_executed
load_succeeded  output  1  one-cycle pulse: response returned
load_succeeded_index  output  IDX_W  index for load_succeeded
rob_commit_load  input  1  ROB commits the load at the head
head_index  output  IDX_W  oldest occupied entry
count  output  IDX_W+1  occupied entries, 0..LDQ_SIZE
flush  input  1  squash all uncommitted loads

Behaviour:
- Reset (async, active-high): head=tail=0, count=0, FSM=IDLE, all outputs 0 except dispatch_ready=1.
- Pointers are IDX_W+1 bits (wrap bit). Index = low IDX_W bits. full = (count==LDQ_SIZE). empty = (count==0).
- dispatch_ready = !full, derived from registered count only. Allocation happens when dispatch_valid && dispatch_ready. alloc_index = tail; tail increments at the next edge.
- rob_commit_load when !empty: head increments at the next edge. It is ignored when empty.
- Alloc and commit in the same cycle: count is unchanged and both pointers advance. When full, alloc is refused even if a commit occurs in the same cycle.
- Candidate = entry_valid & entry_address_valid & ~entry_executed & ~entry_blocked. Select the first candidate scanning from head upward modulo LDQ_SIZE (oldest first), across wrap-around.
- FSM states: IDLE, REQ, WAIT, DRAIN.
  - IDLE: if a candidate exists, latch its index and go to REQ. The request is visible the cycle after the candidate appears.
  - REQ: mem_req_valid=1 and mem_req_index is held stable until handshake. On mem_req_valid && mem_req_ready, pulse load_executed with the latched index in the same cycle, then go to WAIT.
  - WAIT: on mem_resp_valid, pulse load_succeeded with the latched index in the same cycle, then go to IDLE. No new request is issued until return to IDLE (single outstanding).
  - DRAIN: waits for mem_resp_valid, produces no load_succeeded pulse, then goes to IDLE.
- Response arriving in a state other than WAIT/DRAIN is ignored.
- Flush: apply the same-cycle commit first, then tail <= new head and count <= 0. Same-cycle dispatch is discarded. FSM next state:
  - IDLE or REQ without handshake: go to IDLE, mem_req_valid drops the next cycle.
  - REQ with handshake this cycle: go to DRAIN, and load_executed is suppressed.
  - WAIT with no response: go to DRAIN.
  - WAIT with response this cycle: go to IDLE, and load_succeeded is suppressed.
  - DRAIN: stays in DRAIN.
- Reset mid-operation drops any outstanding request with no drain. The memory side is reset concurrently.

Test Plan:
- Reset then 16 dispatches -> alloc_index 0..15, dispatch_ready=0 after the 16th, count=16. A 17th dispatch with a commit in the same cycle -> refused, count=15, head=1.
- Entry 3 becomes a candidate at cycle N, mem_req_ready=0 for 2 cycles -> mem_req_valid from N+1 with index 3 held stable. Handshake at N+3 -> load_executed pulse at index 3. Response 2 cycles later -> load_succeeded pulse at index 3.
- head=14, candidates at indices 1 and 15 -> index 15 issued first; after its response, index 1 issued.
- Candidate at index 5 with entry_blocked[5]=1 -> no request. Clearing blocked -> request issued the next cycle.
- Flush in WAIT (head=2, count=6) -> count=0, tail=2. A subsequent mem_resp_valid produces no load_succeeded. A new candidate issues only after the drain completes.
- reset asserted in WAIT (async, mid-cycle) -> mem_req_valid=0, count=0, dispatch_ready=1 immediately, without waiting for a clock edge.
